// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: sums a WIDTH-bit operand pair CHUNK bits per clock, LSB first,
// through a CHUNK-bit ripple slice with the carry held in a register between chunks.
module seq_addsub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CntW-1:0]  LastCnt   = CntW'(N - 1);
    localparam logic [WIDTH-1:0] ChunkMask = WIDTH'({CHUNK{1'b1}});

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] res_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             out_valid_q;

    logic [IdxW-1:0]  lsb;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] sum_chunk;
    logic             carry;
    logic             c_into_msb;
    logic             c_out;
    logic [WIDTH-1:0] res_merged;

    // Ripple slice over the current chunk; c_into_msb ends up as the carry into the slice's top bit.
    always_comb begin
        lsb        = IdxW'(32'(cnt_q) * CHUNK);
        a_chunk    = a_q[lsb +: CHUNK];
        b_chunk    = b_q[lsb +: CHUNK];
        sum_chunk  = '0;
        carry      = carry_q;
        c_into_msb = carry_q;
        for (int i = 0; i < int'(CHUNK); i++) begin
            c_into_msb   = carry;
            sum_chunk[i] = a_chunk[i] ^ b_chunk[i] ^ carry;
            carry        = (a_chunk[i] & b_chunk[i]) | (carry & (a_chunk[i] ^ b_chunk[i]));
        end
        c_out      = carry;
        res_merged = (res_q & ~(ChunkMask << lsb)) | (WIDTH'(sum_chunk) << lsb);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            res_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        // Subtract as A + ~B + ~borrow.
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{sub}};
                        carry_q <= cin ^ sub;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    res_q   <= res_merged;
                    carry_q <= c_out;
                    cnt_q   <= cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        cout_q      <= c_out;
                        ovf_q       <= c_into_msb ^ c_out;
                        zero_q      <= (res_merged == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        cout_q      <= 1'b0;
                        ovf_q       <= 1'b0;
                        zero_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Gated by rst_n so in_ready reads 0 while reset is held and rises as soon as it releases.
    assign in_ready  = rst_n & (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Directed and golden-model bench for seq_addsub at CHUNK = 4, 1, 8 and 16 (WIDTH = 16).
module tb_seq_addsub;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        in_valid_v;
    logic [15:0]       a;
    logic [15:0]       b;
    logic              sub;
    logic              cin;
    logic              out_ready;
    logic [3:0]        in_ready_w;
    logic [3:0]        out_valid_w;
    logic [3:0][15:0]  res_w;
    logic [3:0]        cout_w;
    logic [3:0]        ovf_w;
    logic [3:0]        zero_w;

    int checks = 0;
    int errors = 0;
    int lat_tab[4] = '{4, 16, 2, 1};

    always #5 clk = ~clk;

    seq_addsub #(.WIDTH(16), .CHUNK(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_w[0]),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .res(res_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0]), .zero(zero_w[0])
    );
    seq_addsub #(.WIDTH(16), .CHUNK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_w[1]),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .res(res_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1]), .zero(zero_w[1])
    );
    seq_addsub #(.WIDTH(16), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_w[2]),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid_w[2]), .out_ready(out_ready),
        .res(res_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2]), .zero(zero_w[2])
    );
    seq_addsub #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(in_ready_w[3]),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid_w[3]), .out_ready(out_ready),
        .res(res_w[3]), .cout(cout_w[3]), .ovf(ovf_w[3]), .zero(zero_w[3])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {ovf, cout, res} computed with plain wide arithmetic.
    function automatic logic [17:0] golden(input logic [15:0] av, input logic [15:0] bv,
                                           input logic s, input logic c);
        logic [15:0] bb;
        logic        c0;
        logic [16:0] full;
        logic [15:0] low;
        bb   = s ? ~bv : bv;
        c0   = c ^ s;
        full = {1'b0, av} + {1'b0, bb} + 17'(c0);
        low  = {1'b0, av[14:0]} + {1'b0, bb[14:0]} + 16'(c0);
        return {low[15] ^ full[16], full[16], full[15:0]};
    endfunction

    // Called #1 after a rising edge with the selected DUT idle; returns edges from accept to valid.
    task automatic start_and_wait(input int sel, input logic [15:0] av, input logic [15:0] bv,
                                  input logic s, input logic c, output int edges);
        a = av;
        b = bv;
        sub = s;
        cin = c;
        in_valid_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v[sel] = 1'b0;
        edges = 0;
        while (!out_valid_w[sel] && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic expect_result(input int sel, input string tag, input int edges,
                                 input logic [15:0] r, input logic co, input logic ov);
        check({tag, " latency"}, edges, lat_tab[sel]);
        check({tag, " out_valid"}, out_valid_w[sel], 1'b1);
        check({tag, " res"}, res_w[sel], r);
        check({tag, " cout"}, cout_w[sel], co);
        check({tag, " ovf"}, ovf_w[sel], ov);
        check({tag, " zero"}, zero_w[sel], r == 16'h0000);
    endtask

    task automatic take_output(input int sel, input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " valid dropped"}, out_valid_w[sel], 1'b0);
        check({tag, " in_ready back"}, in_ready_w[sel], 1'b1);
    endtask

    initial begin
        int          e;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;
        logic        rc;
        logic [17:0] g;

        rst_n = 1'b0;
        in_valid_v = '0;
        a = '0;
        b = '0;
        sub = 1'b0;
        cin = 1'b0;
        out_ready = 1'b0;

        #3;
        check("reset in_ready", in_ready_w[0], 1'b0);
        check("reset out_valid", out_valid_w[0], 1'b0);
        check("reset res", res_w[0], 16'h0000);
        check("reset flags", {cout_w[0], ovf_w[0], zero_w[0]}, 3'b000);
        #9;
        rst_n = 1'b1;
        #1;
        check("release in_ready", in_ready_w[0], 1'b1);
        @(posedge clk);
        #1;

        start_and_wait(0, 16'h1234, 16'h1111, 1'b0, 1'b0, e);
        expect_result(0, "add", e, 16'h2345, 1'b0, 1'b0);
        take_output(0, "add");

        start_and_wait(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, e);
        expect_result(0, "wrap", e, 16'h0000, 1'b1, 1'b0);
        take_output(0, "wrap");

        start_and_wait(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, e);
        expect_result(0, "add ovf", e, 16'h8000, 1'b0, 1'b1);
        take_output(0, "add ovf");

        start_and_wait(0, 16'h0005, 16'h0007, 1'b1, 1'b0, e);
        expect_result(0, "sub neg", e, 16'hFFFE, 1'b0, 1'b0);
        take_output(0, "sub neg");

        start_and_wait(0, 16'h8000, 16'h0001, 1'b1, 1'b0, e);
        expect_result(0, "sub ovf", e, 16'h7FFF, 1'b1, 1'b1);
        take_output(0, "sub ovf");

        start_and_wait(0, 16'h0010, 16'h0001, 1'b1, 1'b1, e);
        expect_result(0, "sub borrow", e, 16'h000E, 1'b1, 1'b0);
        take_output(0, "sub borrow");

        // in_valid held through RUN with operands changing: only the first pair is used.
        a = 16'h0100;
        b = 16'h0200;
        sub = 1'b0;
        cin = 1'b0;
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        a = 16'hAAAA;
        b = 16'h5555;
        check("run in_ready", in_ready_w[0], 1'b0);
        e = 0;
        while (!out_valid_w[0] && e < 40) begin
            @(posedge clk);
            #1;
            e++;
        end
        in_valid_v[0] = 1'b0;
        expect_result(0, "held valid", e, 16'h0300, 1'b0, 1'b0);
        check("done in_ready", in_ready_w[0], 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("stall valid", out_valid_w[0], 1'b1);
            check("stall res", res_w[0], 16'h0300);
            check("stall flags", {cout_w[0], ovf_w[0], zero_w[0]}, 3'b000);
        end
        take_output(0, "stall");

        // Reset two cycles into RUN clears the partial result asynchronously.
        a = 16'h1234;
        b = 16'h1111;
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v[0] = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("partial res", res_w[0], 16'h0045);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort res", res_w[0], 16'h0000);
        check("abort out_valid", out_valid_w[0], 1'b0);
        check("abort in_ready", in_ready_w[0], 1'b0);
        check("abort flags", {cout_w[0], ovf_w[0], zero_w[0]}, 3'b000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post reset in_ready", in_ready_w[0], 1'b1);
        start_and_wait(0, 16'h0001, 16'h0001, 1'b0, 1'b0, e);
        expect_result(0, "post reset", e, 16'h0002, 1'b0, 1'b0);
        take_output(0, "post reset");

        for (int sel = 1; sel < 4; sel++) begin
            for (int n = 0; n < 1000; n++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rs = 1'($urandom_range(0, 1));
                rc = 1'($urandom_range(0, 1));
                g  = golden(ra, rb, rs, rc);
                start_and_wait(sel, ra, rb, rs, rc, e);
                expect_result(sel, $sformatf("sweep%0d", sel), e, g[15:0], g[16], g[17]);
                take_output(sel, $sformatf("sweep%0d", sel));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
